// File: rtl/sha256_stream_core.sv
// -----------------------------------------------------------------------------
// sha256_stream_core
//
// Multi-block SHA-256 engine. Accepts pre-padded 512-bit blocks over a
// valid/ready handshake and chains the intermediate hash internally, starting
// from the standard IV. The final digest is presented over a held valid/ready
// handshake. ROUNDS_PER_CYCLE compression rounds are unrolled per clock, so a
// block takes N = 64/ROUNDS_PER_CYCLE compress cycles plus one FINAL cycle.
//
// Parameters
//   ROUNDS_PER_CYCLE : rounds per clock, legal values 1, 2, 4, 8, 16
//
// Ports
//   i_clk            : clock, all state on rising edge
//   i_rst_n          : asynchronous active-low reset
//   i_blk_valid      : block presented
//   o_blk_ready      : block accepted on edge with valid && ready (IDLE only)
//   i_blk_data[511:0]: padded block, [511:480] = W0, big-endian words
//   i_blk_first      : first block of a message, chain forced to IV
//   i_blk_last       : last block of a message, digest produced after it
//   o_digest_valid   : digest held stable while high
//   i_digest_ready   : digest consumed on edge with valid && ready
//   o_digest[255:0]  : H0..H7, [255:224] = H0
//   o_busy           : high in COMPRESS, FINAL or DONE
// -----------------------------------------------------------------------------
module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [511:0] i_blk_data,
    input  logic         i_blk_first,
    input  logic         i_blk_last,
    output logic         o_digest_valid,
    input  logic         i_digest_ready,
    output logic [255:0] o_digest,
    output logic         o_busy
);

    localparam int R     = ROUNDS_PER_CYCLE;
    localparam int N     = 64 / R;
    localparam int LOG2R = $clog2(R);
    localparam logic [5:0] LAST_CNT = 6'(N - 1);

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMPRESS = 2'd1,
        S_FINAL    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // SHA-256 logical functions
    // -------------------------------------------------------------------------
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t       r_state;
    logic [5:0]   r_cnt;
    logic         r_last;
    logic         r_blk_ready;
    logic         r_digest_valid;
    logic         r_busy;
    logic [255:0] r_digest;
    logic [31:0]  r_h  [0:7];   // chaining value H0..H7
    logic [31:0]  r_st [0:7];   // working variables a..h
    logic [31:0]  r_w  [0:15];  // schedule window, r_w[0] = W(t)

    // -------------------------------------------------------------------------
    // Block unpacking and final addition
    // -------------------------------------------------------------------------
    logic [31:0]  w_blk_word [0:15];
    logic [31:0]  w_h_sum    [0:7];
    logic [255:0] w_h_sum_packed;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            assign w_blk_word[gi] = i_blk_data[511 - 32*gi -: 32];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_final
            assign w_h_sum[gi] = r_h[gi] + r_st[gi];
            assign w_h_sum_packed[255 - 32*gi -: 32] = w_h_sum[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // R chained rounds per cycle. The schedule window slides by one word per
    // round: W(t) is consumed from the head and W(t+16) is appended at the
    // tail. Words produced during the last 16 rounds are never used, which is
    // harmless and keeps the datapath uniform.
    // -------------------------------------------------------------------------
    logic [5:0]  w_base;
    logic [31:0] w_rnd_st [0:7];
    logic [31:0] w_rnd_w  [0:15];
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [31:0] w_new;

    always_comb begin
        w_base = r_cnt << LOG2R;
        w_t1   = '0;
        w_t2   = '0;
        w_new  = '0;
        for (int j = 0; j < 8; j++) begin
            w_rnd_st[j] = r_st[j];
        end
        for (int j = 0; j < 16; j++) begin
            w_rnd_w[j] = r_w[j];
        end
        for (int i = 0; i < R; i++) begin
            w_t1 = w_rnd_st[7] + big_sigma1(w_rnd_st[4])
                 + ((w_rnd_st[4] & w_rnd_st[5]) ^ (~w_rnd_st[4] & w_rnd_st[6]))
                 + K[w_base + 6'(i)] + w_rnd_w[0];
            w_t2 = big_sigma0(w_rnd_st[0])
                 + ((w_rnd_st[0] & w_rnd_st[1]) ^ (w_rnd_st[0] & w_rnd_st[2])
                    ^ (w_rnd_st[1] & w_rnd_st[2]));
            w_new = small_sigma1(w_rnd_w[14]) + w_rnd_w[9]
                  + small_sigma0(w_rnd_w[1]) + w_rnd_w[0];

            w_rnd_st[7] = w_rnd_st[6];
            w_rnd_st[6] = w_rnd_st[5];
            w_rnd_st[5] = w_rnd_st[4];
            w_rnd_st[4] = w_rnd_st[3] + w_t1;
            w_rnd_st[3] = w_rnd_st[2];
            w_rnd_st[2] = w_rnd_st[1];
            w_rnd_st[1] = w_rnd_st[0];
            w_rnd_st[0] = w_t1 + w_t2;

            for (int j = 0; j < 15; j++) begin
                w_rnd_w[j] = w_rnd_w[j + 1];
            end
            w_rnd_w[15] = w_new;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake outputs. r_blk_ready resets low
    // and rises on the first edge after reset release.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_last         <= 1'b0;
            r_blk_ready    <= 1'b0;
            r_digest_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_digest       <= '0;
            for (int j = 0; j < 8; j++) begin
                r_h[j]  <= IV[j];
                r_st[j] <= '0;
            end
            for (int j = 0; j < 16; j++) begin
                r_w[j] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_blk_ready <= 1'b1;
                    if (i_blk_valid && r_blk_ready) begin
                        for (int j = 0; j < 16; j++) begin
                            r_w[j] <= w_blk_word[j];
                        end
                        // blk_first abandons any chain in progress
                        for (int j = 0; j < 8; j++) begin
                            if (i_blk_first) begin
                                r_h[j]  <= IV[j];
                                r_st[j] <= IV[j];
                            end else begin
                                r_st[j] <= r_h[j];
                            end
                        end
                        r_last      <= i_blk_last;
                        r_cnt       <= '0;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_COMPRESS;
                    end
                end

                S_COMPRESS: begin
                    for (int j = 0; j < 8; j++) begin
                        r_st[j] <= w_rnd_st[j];
                    end
                    for (int j = 0; j < 16; j++) begin
                        r_w[j] <= w_rnd_w[j];
                    end
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end

                S_FINAL: begin
                    for (int j = 0; j < 8; j++) begin
                        r_h[j] <= w_h_sum[j];
                    end
                    if (r_last) begin
                        r_digest       <= w_h_sum_packed;
                        r_digest_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_blk_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                S_DONE: begin
                    if (i_digest_ready) begin
                        // next message starts from IV even without blk_first
                        for (int j = 0; j < 8; j++) begin
                            r_h[j] <= IV[j];
                        end
                        r_digest_valid <= 1'b0;
                        r_blk_ready    <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_blk_ready    = r_blk_ready;
    assign o_digest_valid = r_digest_valid;
    assign o_digest       = r_digest;
    assign o_busy         = r_busy;

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Multi-block SHA-256 hashing engine and parametrised successor of `sha256_block`. It accepts a stream of pre-padded 512-bit message blocks over a valid/ready handshake and chains the intermediate hash internally, starting from the standard IV. It returns the final 256-bit digest over a held valid/ready handshake. The number of compression rounds per clock is configurable, trading area for latency. Padding is performed upstream.

## Interface
- ROUNDS_PER_CYCLE, 1, rounds per clock; legal values 1, 2, 4, 8, 16; sets N = 64/ROUNDS_PER_CYCLE.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- blk_valid  input  1  block presented.
- blk_ready  output  1  block accepted on an edge where blk_valid && blk_ready.
- blk_data  input  512  padded block; [511:480] = W0, big-endian words.
- blk_first  input  1  first block of message; chaining value forced to IV.
- blk_last  input  1  last block of message; digest produced after it.
- digest_valid  output  1  digest held stable while high.
- digest_ready  input  1  digest consumed on an edge where digest_valid && digest_ready.
- digest  output  256  H0..H7; [255:224] = H0.
- busy  output  1  high in COMPRESS, FINAL or DONE.

## Operation
- States:
  - IDLE: blk_ready=1.
  - COMPRESS: round counter runs 0..N-1.
  - FINAL: eight 32-bit additions mod 2^32 into the chaining H.
  - DONE: digest_valid=1.
- Transitions:
  - IDLE→COMPRESS on block accept.
  - Accept latches blk_data into a 16-word schedule shift register and blk_last into a flag.
  - Accept loads a..h from IV if blk_first, else from chaining H.
  - When blk_first, chaining H is also reloaded with IV on the same edge.
  - COMPRESS performs ROUNDS_PER_CYCLE chained rounds per edge with the standard Wt/Kt; Kt comes from a 64-entry constant ROM.
  - COMPRESS→FINAL after the counter completes N-1.
  - FINAL→DONE if the last flag is set, else FINAL→IDLE.
  - DONE→IDLE on digest accept; chaining H is reset to IV on that edge.
- All additions are 32-bit with carries discarded. Schedule: Wt = σ1(Wt-2)+Wt-7+σ0(Wt-15)+Wt-16 for t≥16.
- The digest register updates only in FINAL when the last flag is set. It holds its value through DONE and afterward until the next last-block FINAL.
- blk_ready=0 outside IDLE; blk_valid is ignored there and the block must be held by the source.
- blk_first mid-message (IDLE after a non-last block) abandons the old chain and restarts from IV.
- A block without blk_first at the start of a fresh message uses IV, since chaining H resets to IV after each digest.
- blk_first && blk_last on the same block is a single-block message.
- A reset assertion at any time (including mid-COMPRESS or in DONE) returns to IDLE immediately. The partial message is discarded.
- Reset values:
  - Outputs: blk_ready=0 while rst=0, then 1 in IDLE; digest_valid=0; digest=0; busy=0.
  - Internal state: chaining H=IV, counter=0.

## Timing
- Block accepted on edge E0.
- COMPRESS occupies edges E1..EN; FINAL is on edge EN+1.
- digest_valid rises after EN+1, i.e. N+1 cycles after acceptance (65 for R=1, 17 for R=4).
- For a non-last block, blk_ready rises after EN+1; the next accept is earliest at EN+2. Throughput is N+2 cycles/block.
- A digest accepted on edge D makes blk_ready=1 in the following cycle.
- digest_ready held high while in DONE gives a single-cycle digest_valid pulse.
- blk_ready, digest_valid and busy are registered state decodes with no combinational input→output paths.

## Test plan
- R=1, "abc" padded (61626380…0018), first=last=1 → digest_valid 65 cycles after accept, digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- R=1, empty message (80000000…0) → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- R=4, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 1 first=1, block 2 last=1) → no digest_valid after block 1; after block 2, 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1 at 17 cycles.
- Backpressure: hold digest_ready=0 for 10 cycles in DONE → digest stable, blk_ready=0, blk_valid ignored. Release → handshake completes, then a new "abc" message reproduces the same digest (chain reset to IV).
- Reset mid-COMPRESS (rst=0 at round 30 of block 1 of the two-block message) → digest_valid=0, busy=0, blk_ready=1 after release. A following "abc" gives the correct digest.
- blk_first re-asserted on the second block: send block 1 of the two-block message (first=1, last=0), then "abc" with first=1,last=1 → ba7816bf…f20015ad.
